time_set_encoder: RTL

TIME_SET_ENCODER -- requirements
Module: time_set_encoder

---
 rtl/time_set_encoder_if.sv | 25 ++
 rtl/time_set_encoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/time_set_encoder_if.sv
// Digit-entry handshake and published-time bus for time_set_encoder.
// The keypad side uses the master modport; the encoder uses slave.
interface time_set_encoder_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       backspace;
  logic       cancel;
  logic       busy;
  logic [2:0] digit_index;
  logic       reject;
  logic       load;
  logic [4:0] out_hrs;
  logic [5:0] out_min;
  logic [5:0] out_sec;

  modport master (
    output digit_valid, digit, backspace, cancel,
    input  busy, digit_index, reject, load, out_hrs, out_min, out_sec
  );

  modport slave (
    input  digit_valid, digit, backspace, cancel,
    output busy, digit_index, reject, load, out_hrs, out_min, out_sec
  );
endinterface

// File: rtl/time_set_encoder.sv
// Sequential BCD time entry (HT HO MT MO [ST SO]) to binary hours/minutes/seconds.
// Define SECONDS_ENTRY_EN for six-digit entry with seconds; default is four digits, out_sec tied to 0.
module time_set_encoder #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input logic               clk,
  input logic               reset,
  time_set_encoder_if.slave bus
);

`ifdef SECONDS_ENTRY_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;

  state_t      r_state;
  logic [2:0]  r_index;
  logic [31:0] r_idle_cnt;
  logic        r_reject;
  logic        r_load;
  logic [1:0]  r_ht;
  logic [3:0]  r_ho;
  logic [2:0]  r_mt;
  logic [4:0]  r_hrs;
  logic [5:0]  r_min;
`ifdef SECONDS_ENTRY_EN
  logic [3:0]  r_mo;
  logic [2:0]  r_st;
  logic [5:0]  r_sec;
`endif

  logic       w_digit_ok;
  logic       w_cancel;
  logic       w_bksp;
  logic       w_offer;
  logic       w_accept;
  logic       w_refuse;
  logic       w_store;
  logic [4:0] w_hrs;
  logic [5:0] w_min;
`ifdef SECONDS_ENTRY_EN
  logic [5:0] w_sec;
`endif

  // Cancel beats backspace beats a digit offer; losers are simply dropped.
  assign w_cancel = bus.cancel;
  assign w_bksp   = bus.backspace & ~bus.cancel;
  assign w_offer  = bus.digit_valid & ~bus.backspace & ~bus.cancel;
  assign w_accept = w_offer & w_digit_ok;
  assign w_refuse = w_offer & ~w_digit_ok;
  assign w_store  = w_accept & (r_state != COMMIT);

  always_comb begin
    w_digit_ok = 1'b0;
    case (r_index)
      3'd0:    w_digit_ok = (bus.digit <= 4'd2);
      3'd1:    w_digit_ok = (r_ht == 2'd2) ? (bus.digit <= 4'd3) : (bus.digit <= 4'd9);
      3'd2:    w_digit_ok = (bus.digit <= 4'd5);
      3'd3:    w_digit_ok = (bus.digit <= 4'd9);
`ifdef SECONDS_ENTRY_EN
      3'd4:    w_digit_ok = (bus.digit <= 4'd5);
      3'd5:    w_digit_ok = (bus.digit <= 4'd9);
`endif
      default: w_digit_ok = 1'b0;
    endcase
  end

  // The final digit is folded in straight from the bus, so outputs land on the edge that raises load.
  assign w_hrs = ({3'b000, r_ht} << 3) + ({3'b000, r_ht} << 1) + {1'b0, r_ho};
`ifdef SECONDS_ENTRY_EN
  assign w_min = ({3'b000, r_mt} << 3) + ({3'b000, r_mt} << 1) + {2'b00, r_mo};
  assign w_sec = ({3'b000, r_st} << 3) + ({3'b000, r_st} << 1) + {2'b00, bus.digit};
`else
  assign w_min = ({3'b000, r_mt} << 3) + ({3'b000, r_mt} << 1) + {2'b00, bus.digit};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_index    <= 3'd0;
      r_idle_cnt <= 32'd0;
      r_reject   <= 1'b0;
      r_load     <= 1'b0;
      r_ht       <= 2'd0;
      r_ho       <= 4'd0;
      r_mt       <= 3'd0;
      r_hrs      <= 5'd0;
      r_min      <= 6'd0;
`ifdef SECONDS_ENTRY_EN
      r_mo       <= 4'd0;
      r_st       <= 3'd0;
      r_sec      <= 6'd0;
`endif
    end else begin
      r_reject <= 1'b0;
      r_load   <= 1'b0;

      if (w_store) begin
        case (r_index)
          3'd0:    r_ht <= bus.digit[1:0];
          3'd1:    r_ho <= bus.digit;
          3'd2:    r_mt <= bus.digit[2:0];
`ifdef SECONDS_ENTRY_EN
          3'd3:    r_mo <= bus.digit;
          3'd4:    r_st <= bus.digit[2:0];
`endif
          default: ;
        endcase
      end

      case (r_state)
        IDLE: begin
          r_index    <= 3'd0;
          r_idle_cnt <= 32'd0;
          if (w_accept) begin
            r_index <= 3'd1;
            r_state <= ENTRY;
          end else if (w_refuse) begin
            r_reject <= 1'b1;
          end
        end

        ENTRY: begin
          if (w_cancel) begin
            r_state    <= IDLE;
            r_index    <= 3'd0;
            r_idle_cnt <= 32'd0;
          end else if (w_bksp) begin
            r_idle_cnt <= 32'd0;
            r_index    <= r_index - 3'd1;
            if (r_index == 3'd1) begin
              r_state <= IDLE;
            end
          end else if (w_accept) begin
            r_idle_cnt <= 32'd0;
            if (r_index == LAST_IDX) begin
              r_state <= COMMIT;
              r_load  <= 1'b1;
              r_hrs   <= w_hrs;
              r_min   <= w_min;
`ifdef SECONDS_ENTRY_EN
              r_sec   <= w_sec;
`endif
            end else begin
              r_index <= r_index + 3'd1;
            end
          end else begin
            r_reject <= w_refuse;
            if (r_idle_cnt == TIMEOUT_LAST) begin
              r_state    <= IDLE;
              r_index    <= 3'd0;
              r_idle_cnt <= 32'd0;
            end else begin
              r_idle_cnt <= r_idle_cnt + 32'd1;
            end
          end
        end

        COMMIT: begin
          r_state <= IDLE;
          r_index <= 3'd0;
        end

        default: begin
          r_state <= IDLE;
          r_index <= 3'd0;
        end
      endcase
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.digit_index = r_index;
  assign bus.reject      = r_reject;
  assign bus.load        = r_load;
  assign bus.out_hrs     = r_hrs;
  assign bus.out_min     = r_min;
`ifdef SECONDS_ENTRY_EN
  assign bus.out_sec     = r_sec;
`else
  assign bus.out_sec     = 6'd0;
`endif

endmodule
